memch_channel_sequencer: RTL and testbench

- Input-side companion to the memory channel controller. Accepts a raster stream of pixels and writes them into channel memories 1, 2 and 3, one channel at a time.
- Raises New_Channel_Flag when the current channel is full, then waits for the controller's Counter_En pulse before moving to the next channel.
- Consumes the controller's active-low channel-counter clear (Counter_Ch_Clr).

---
 rtl/memch_channel_sequencer.sv | 160 ++++++++++++++++
 tb/tb_memch_channel_sequencer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/memch_channel_sequencer.sv
// memch_channel_sequencer
//   Loads a raster pixel stream into channel memories 1, 2 and 3, one channel at a time.
//   After IMG_PIXELS accepted pixels the channel is full: New_Channel_Flag rises and the
//   block waits for a Counter_En pulse from the controller before filling the next channel.
//   After the third channel, Counter_En moves the block to DONE.
//   All registers update on the falling edge of MEMCH_CHSEQ_Clk.
//
// Optional feature: define MEMCH_CHSEQ_OVERRUN_EN to add the sticky MEMCH_CHSEQ_Overrun
// status output. It is set when a pixel is presented while FULL or DONE.
//
// Ports:
//   MEMCH_CHSEQ_Clk            clock (falling-edge active)
//   MEMCH_CHSEQ_Reset          asynchronous active-low reset
//   MEMCH_CHSEQ_Ch_Clr         synchronous active-low clear (controller Counter_Ch_Clr)
//   MEMCH_CHSEQ_Counter_En     one-cycle advance pulse
//   MEMCH_CHSEQ_Pixel_Valid    upstream pixel valid
//   MEMCH_CHSEQ_Pixel_Data     upstream pixel
//   MEMCH_CHSEQ_Pixel_Ready    block accepts a pixel (FILL only)
//   MEMCH_CHSEQ_ChmemN_Wr      one-hot channel-memory write strobes
//   MEMCH_CHSEQ_Chmem_Addr     write address
//   MEMCH_CHSEQ_Chmem_Data     write data
//   MEMCH_CHSEQ_Channel_Index  current channel, 0..2
//   MEMCH_CHSEQ_New_Channel_Flag  current channel full
//   MEMCH_CHSEQ_All_Done       all three channels loaded
//   MEMCH_CHSEQ_Overrun        sticky overrun status (optional)

module memch_channel_sequencer #(
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned ADDR_W     = 10,
   parameter int unsigned IMG_PIXELS = 784
) (
   input  logic              MEMCH_CHSEQ_Clk,
   input  logic              MEMCH_CHSEQ_Reset,
   input  logic              MEMCH_CHSEQ_Ch_Clr,
   input  logic              MEMCH_CHSEQ_Counter_En,
   input  logic              MEMCH_CHSEQ_Pixel_Valid,
   input  logic [DATA_W-1:0] MEMCH_CHSEQ_Pixel_Data,
   output logic              MEMCH_CHSEQ_Pixel_Ready,
   output logic              MEMCH_CHSEQ_Chmem1_Wr,
   output logic              MEMCH_CHSEQ_Chmem2_Wr,
   output logic              MEMCH_CHSEQ_Chmem3_Wr,
   output logic [ADDR_W-1:0] MEMCH_CHSEQ_Chmem_Addr,
   output logic [DATA_W-1:0] MEMCH_CHSEQ_Chmem_Data,
   output logic [1:0]        MEMCH_CHSEQ_Channel_Index,
   output logic              MEMCH_CHSEQ_New_Channel_Flag,
`ifdef MEMCH_CHSEQ_OVERRUN_EN
   output logic              MEMCH_CHSEQ_Overrun,
`endif
   output logic              MEMCH_CHSEQ_All_Done
);

   typedef enum logic [1:0] {StIdle, StFill, StFull, StDone} state_e;

   localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(IMG_PIXELS - 1);

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   cnt_q, cnt_d;
   logic [1:0]          idx_q, idx_d;
   logic [2:0]          wr_q, wr_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   data_q, data_d;
`ifdef MEMCH_CHSEQ_OVERRUN_EN
   logic                overrun_q, overrun_d;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      wr_d    = '0;
      addr_d  = addr_q;
      data_d  = data_q;
`ifdef MEMCH_CHSEQ_OVERRUN_EN
      overrun_d = overrun_q;
`endif
      if (!MEMCH_CHSEQ_Ch_Clr) begin
         // Clear wins over every other input in the same cycle.
         state_d = StIdle;
         cnt_d   = '0;
         idx_d   = '0;
         addr_d  = '0;
         data_d  = '0;
`ifdef MEMCH_CHSEQ_OVERRUN_EN
         overrun_d = 1'b0;
`endif
      end else begin
         unique case (state_q)
            StIdle: state_d = StFill;
            StFill: begin
               if (MEMCH_CHSEQ_Pixel_Valid) begin
                  wr_d   = 3'(1) << idx_q;
                  addr_d = cnt_q;
                  data_d = MEMCH_CHSEQ_Pixel_Data;
                  if (cnt_q == LastAddr) begin
                     cnt_d   = '0;
                     state_d = StFull;
                  end else begin
                     cnt_d = cnt_q + ADDR_W'(1);
                  end
               end
            end
            StFull: begin
               if (MEMCH_CHSEQ_Counter_En) begin
                  if (idx_q < 2'd2) begin
                     idx_d   = idx_q + 2'd1;
                     state_d = StFill;
                  end else begin
                     state_d = StDone;
                  end
               end
            end
            StDone: state_d = StDone;
            default: state_d = StIdle;
         endcase
`ifdef MEMCH_CHSEQ_OVERRUN_EN
         if (MEMCH_CHSEQ_Pixel_Valid && (state_q == StFull || state_q == StDone)) begin
            overrun_d = 1'b1;
         end
`endif
      end
   end

   always_ff @(negedge MEMCH_CHSEQ_Clk or negedge MEMCH_CHSEQ_Reset) begin
      if (!MEMCH_CHSEQ_Reset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         idx_q   <= '0;
         wr_q    <= '0;
         addr_q  <= '0;
         data_q  <= '0;
`ifdef MEMCH_CHSEQ_OVERRUN_EN
         overrun_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
`ifdef MEMCH_CHSEQ_OVERRUN_EN
         overrun_q <= overrun_d;
`endif
      end
   end

   assign MEMCH_CHSEQ_Pixel_Ready      = (state_q == StFill);
   assign MEMCH_CHSEQ_Chmem1_Wr        = wr_q[0];
   assign MEMCH_CHSEQ_Chmem2_Wr        = wr_q[1];
   assign MEMCH_CHSEQ_Chmem3_Wr        = wr_q[2];
   assign MEMCH_CHSEQ_Chmem_Addr       = addr_q;
   assign MEMCH_CHSEQ_Chmem_Data       = data_q;
   assign MEMCH_CHSEQ_Channel_Index    = idx_q;
   assign MEMCH_CHSEQ_New_Channel_Flag = (state_q == StFull);
   assign MEMCH_CHSEQ_All_Done         = (state_q == StDone);
`ifdef MEMCH_CHSEQ_OVERRUN_EN
   assign MEMCH_CHSEQ_Overrun          = overrun_q;
`endif

endmodule

// File: tb/tb_memch_channel_sequencer.sv
// Directed bench for memch_channel_sequencer with IMG_PIXELS = 4, ADDR_W = 2.
// Registers update on the falling clock edge; outputs are sampled 1 time unit after it.
// wvec = {Chmem3_Wr, Chmem2_Wr, Chmem1_Wr, Addr, Data}
// svec = {Pixel_Ready, New_Channel_Flag, All_Done, Channel_Index}

module tb_memch_channel_sequencer;

   logic       clk = 1'b1;
   logic       rst_n;
   logic       ch_clr;
   logic       cnt_en;
   logic       valid;
   logic [7:0] pdata;
   logic       ready, wr1, wr2, wr3, flag, done;
   logic [1:0] addr, idx;
   logic [7:0] wdata;
`ifdef MEMCH_CHSEQ_OVERRUN_EN
   logic       overrun;
`endif

   int tests = 0;
   int fails = 0;

   logic [12:0] wvec;
   logic [4:0]  svec;
   assign wvec = {wr3, wr2, wr1, addr, wdata};
   assign svec = {ready, flag, done, idx};

   memch_channel_sequencer #(
      .DATA_W     (8),
      .ADDR_W     (2),
      .IMG_PIXELS (4)
   ) dut (
      .MEMCH_CHSEQ_Clk              (clk),
      .MEMCH_CHSEQ_Reset            (rst_n),
      .MEMCH_CHSEQ_Ch_Clr           (ch_clr),
      .MEMCH_CHSEQ_Counter_En       (cnt_en),
      .MEMCH_CHSEQ_Pixel_Valid      (valid),
      .MEMCH_CHSEQ_Pixel_Data       (pdata),
      .MEMCH_CHSEQ_Pixel_Ready      (ready),
      .MEMCH_CHSEQ_Chmem1_Wr        (wr1),
      .MEMCH_CHSEQ_Chmem2_Wr        (wr2),
      .MEMCH_CHSEQ_Chmem3_Wr        (wr3),
      .MEMCH_CHSEQ_Chmem_Addr       (addr),
      .MEMCH_CHSEQ_Chmem_Data       (wdata),
      .MEMCH_CHSEQ_Channel_Index    (idx),
      .MEMCH_CHSEQ_New_Channel_Flag (flag),
`ifdef MEMCH_CHSEQ_OVERRUN_EN
      .MEMCH_CHSEQ_Overrun          (overrun),
`endif
      .MEMCH_CHSEQ_All_Done         (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next active (falling) edge.
   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   // Stream n pixels base+i into the current channel; w is the expected one-hot strobe.
   task automatic stream(input string tag, input logic [2:0] w, input int n,
                         input logic [7:0] base);
      for (int i = 0; i < n; i++) begin
         valid = 1'b1;
         pdata = base + 8'(i);
         tick();
         chk(tag, 32'(wvec), 32'({w, 2'(i), base + 8'(i)}));
      end
   endtask

   initial begin
      rst_n  = 1'b0;
      ch_clr = 1'b1;
      cnt_en = 1'b0;
      valid  = 1'b0;
      pdata  = 8'h00;
      #12;
      chk("rst_wvec", 32'(wvec), 32'h0);
      chk("rst_svec", 32'(svec), 32'h0);
`ifdef MEMCH_CHSEQ_OVERRUN_EN
      chk("rst_overrun", 32'(overrun), 32'h0);
`endif

      rst_n  = 1'b1;
      ch_clr = 1'b0;
      tick();
      tick();
      chk("clr_wvec", 32'(wvec), 32'h0);
      chk("clr_svec", 32'(svec), 32'h0);

      ch_clr = 1'b1;
      tick();
      chk("idle_to_fill", 32'(svec), 32'(5'b10000));

      // Channel 1: 0x11, 0x22, 0x33, 0x44 at addr 0..3.
      for (int i = 0; i < 4; i++) begin
         valid = 1'b1;
         pdata = 8'h11 * 8'(i + 1);
         tick();
         chk("ch1_write", 32'(wvec), 32'({3'b001, 2'(i), 8'h11 * 8'(i + 1)}));
      end
      chk("ch1_full", 32'(svec), 32'(5'b01000));

      // Hold a pixel in FULL: nothing may be written.
      pdata = 8'h55;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("full_no_wr", 32'(wvec[12:10]), 32'h0);
         chk("full_svec", 32'(svec), 32'(5'b01000));
      end
`ifdef MEMCH_CHSEQ_OVERRUN_EN
      chk("overrun_set", 32'(overrun), 32'h1);
`endif
      cnt_en = 1'b1;
      tick();
      cnt_en = 1'b0;
      chk("adv_to_ch2", 32'(svec), 32'(5'b10001));
      chk("adv_no_wr", 32'(wvec[12:10]), 32'h0);
`ifdef MEMCH_CHSEQ_OVERRUN_EN
      chk("overrun_sticky", 32'(overrun), 32'h1);
`endif

      // Channel 2: 0x55 lands at addr 0, then 0x56..0x58.
      stream("ch2_write", 3'b010, 4, 8'h55);
      chk("ch2_full", 32'(svec), 32'(5'b01001));
      cnt_en = 1'b1;
      tick();
      cnt_en = 1'b0;
      chk("adv_to_ch3", 32'(svec), 32'(5'b10010));

      stream("ch3_write", 3'b100, 4, 8'hA0);
      chk("ch3_full", 32'(svec), 32'(5'b01010));
      cnt_en = 1'b1;
      tick();
      chk("done_svec", 32'(svec), 32'(5'b00110));
      tick();
      cnt_en = 1'b0;
      chk("done_hold", 32'(svec), 32'(5'b00110));
      chk("done_no_wr", 32'(wvec[12:10]), 32'h0);

      // Clear from DONE, refill channel 1, then part of channel 2.
      valid  = 1'b0;
      ch_clr = 1'b0;
      tick();
      chk("clr2_svec", 32'(svec), 32'h0);
`ifdef MEMCH_CHSEQ_OVERRUN_EN
      chk("overrun_clr", 32'(overrun), 32'h0);
`endif
      ch_clr = 1'b1;
      tick();
      stream("re_ch1", 3'b001, 4, 8'h01);
      valid  = 1'b0;
      cnt_en = 1'b1;
      tick();
      cnt_en = 1'b0;
      stream("re_ch2", 3'b010, 2, 8'h21);

      // At addr 2 of channel 2: clear with Counter_En and a valid pixel in the same cycle.
      ch_clr = 1'b0;
      cnt_en = 1'b1;
      valid  = 1'b1;
      pdata  = 8'h23;
      tick();
      chk("clr_mid_wvec", 32'(wvec), 32'h0);
      chk("clr_mid_svec", 32'(svec), 32'h0);
      ch_clr = 1'b1;
      cnt_en = 1'b0;
      tick();
      chk("clr_mid_idle", 32'(wvec), 32'h0);
      chk("clr_mid_ready", 32'(svec), 32'(5'b10000));
      tick();
      chk("restart_addr0", 32'(wvec), 32'({3'b001, 2'd0, 8'h23}));

      // Async reset drops the pending strobe without waiting for an edge.
      rst_n = 1'b0;
      #1;
      chk("async_rst_wvec", 32'(wvec), 32'h0);
      chk("async_rst_svec", 32'(svec), 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
